// File: rtl/fix_pkg.sv
// Shared fixed-point constants and helpers for the adder/subtractor family.
// Saturation limits are derived from the operand width so every block agrees on them.
package fix_pkg;

  localparam int FIX_WIDTH = 16;

  localparam logic [FIX_WIDTH-1:0] FIX_MAX = {1'b0, {(FIX_WIDTH-1){1'b1}}};
  localparam logic [FIX_WIDTH-1:0] FIX_MIN = {1'b1, {(FIX_WIDTH-1){1'b0}}};

  localparam logic [15:0] SAT_CNT_MAX = 16'hFFFF;

  // A (W+1)-bit two's-complement value fits in W bits iff its top two bits agree.
  function automatic logic fix_ovf(input logic msb, input logic msb_m1);
    return msb ^ msb_m1;
  endfunction

endpackage

// File: rtl/fix_sat.sv
// Reduces a WIDTH+1-bit signed difference to WIDTH bits, either clipping to the
// representable range (SAT_EN=1) or keeping the low bits (SAT_EN=0).
module fix_sat
  import fix_pkg::*;
#(
  parameter int WIDTH  = FIX_WIDTH,
  parameter int SAT_EN = 1
) (
  input  logic [WIDTH:0]   i_diff,
  output logic [WIDTH-1:0] o_res,
  output logic             o_sat
);

  localparam logic SAT_ON = (SAT_EN != 32'sd0);

  logic             w_ovf;
  logic [WIDTH-1:0] w_clip;

  assign w_ovf  = fix_ovf(i_diff[WIDTH], i_diff[WIDTH-1]);
  // The true sign is the extra top bit; clip toward it.
  assign w_clip = {i_diff[WIDTH], {(WIDTH-1){~i_diff[WIDTH]}}};

  // Select clipped or wrapped result.
  always_comb begin
    o_res = i_diff[WIDTH-1:0];
    o_sat = 1'b0;
    if (SAT_ON && w_ovf) begin
      o_res = w_clip;
      o_sat = 1'b1;
    end else begin
      o_res = i_diff[WIDTH-1:0];
      o_sat = 1'b0;
    end
  end

endmodule

// File: rtl/fix_sub_pipe.sv
// Two-stage valid/ready fixed-point subtractor: stage 1 holds the full-precision
// difference, stage 2 holds the clipped/wrapped result plus a saturation counter.
module fix_sub_pipe
  import fix_pkg::*;
#(
  parameter int WIDTH  = FIX_WIDTH,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_sat,
  output logic [15:0]      sat_count,
  input  logic             sat_count_clr
);

  logic             r_s1_valid;
  logic [WIDTH:0]   r_s1_diff;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_diff;
  logic             r_out_sat;
  logic [15:0]      r_sat_count;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_sat;

  assign w_s2_adv = !r_out_valid || out_ready;
  // Held low through reset so nothing is consumed while the pipe is being cleared.
  assign w_s1_adv = !rst && (!r_s1_valid || w_s2_adv);
  assign w_diff   = {in_a[WIDTH-1], in_a} - {in_b[WIDTH-1], in_b};

  fix_sat #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_sat (
    .i_diff (r_s1_diff),
    .o_res  (w_res),
    .o_sat  (w_sat)
  );

  // Stage 1: full-precision difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_diff  <= {(WIDTH+1){1'b0}};
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_diff <= w_diff;
      end
    end
  end

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_diff  <= {WIDTH{1'b0}};
      r_out_sat   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_diff <= w_res;
        r_out_sat  <= w_sat;
      end
    end
  end

  // Saturation event counter; clear has priority, count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_count <= 16'd0;
    end else if (sat_count_clr) begin
      r_sat_count <= 16'd0;
    end else if (w_s2_adv && r_s1_valid && w_sat && (r_sat_count != SAT_CNT_MAX)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_out_valid;
  assign out_diff  = r_out_diff;
  assign out_sat   = r_out_sat;
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_fix_sub_pipe.sv
// Randomized bench for fix_sub_pipe: saturating and wrapping instances share one
// stimulus stream and are scored against an arithmetic reference queue.
module tb_fix_sub_pipe;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] d_sat;
    logic         s;
    logic [W-1:0] d_wrap;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_ready = 1'b1;
  logic         sat_count_clr = 1'b0;

  logic         in_ready, out_valid, out_sat;
  logic [W-1:0] out_diff;
  logic [15:0]  sat_count;
  logic         w_in_ready, w_out_valid, w_out_sat;
  logic [W-1:0] w_out_diff;
  logic [15:0]  w_sat_count;

  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  exp_q[$];
  logic [15:0] model_cnt = 16'd0;

  fix_sub_pipe #(.WIDTH(W), .SAT_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_sat(out_sat), .sat_count(sat_count),
    .sat_count_clr(sat_count_clr)
  );

  fix_sub_pipe #(.WIDTH(W), .SAT_EN(0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_diff(w_out_diff), .out_sat(w_out_sat), .sat_count(w_sat_count),
    .sat_count_clr(sat_count_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer difference, then clip or keep low bits.
  function automatic exp_t ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   d;
    d = int'($signed(a)) - int'($signed(b));
    e.d_wrap = d[W-1:0];
    if (d > 32767) begin
      e.d_sat = 16'h7FFF; e.s = 1'b1;
    end else if (d < -32768) begin
      e.d_sat = 16'h8000; e.s = 1'b1;
    end else begin
      e.d_sat = d[W-1:0]; e.s = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] t;
    t = 16'($urandom_range(15));
    case ($urandom_range(3))
      0: return 16'h7FF0 + t;
      1: return 16'h8000 + t;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: every transfer edge is decided by the values seen at the preceding negedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check_eq("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
      exp_q.delete();
      model_cnt = 16'd0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          check_eq("diff", {16'd0, out_diff}, {16'd0, exp_q[0].d_sat});
          check_eq("sat", {31'd0, out_sat}, {31'd0, exp_q[0].s});
          check_eq("wrap_valid", {31'd0, w_out_valid}, 32'd1);
          check_eq("wrap_diff", {16'd0, w_out_diff}, {16'd0, exp_q[0].d_wrap});
          check_eq("wrap_sat", {31'd0, w_out_sat}, 32'd0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e = ref_sub(in_a, in_b);
        exp_q.push_back(e);
        if (e.s && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      end
    end
  end

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc = 0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("send_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_expect(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] e_sat, input logic e_s,
                             input logic [W-1:0] e_wrap);
    send_pair(a, b);
    @(negedge clk);
    check_eq("lat_not_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("lat_valid", {31'd0, out_valid}, 32'd1);
    check_eq("dir_diff", {16'd0, out_diff}, {16'd0, e_sat});
    check_eq("dir_sat", {31'd0, out_sat}, {31'd0, e_s});
    check_eq("dir_wrap", {16'd0, w_out_diff}, {16'd0, e_wrap});
    check_eq("dir_wrap_sat", {31'd0, w_out_sat}, 32'd0);
  endtask

  task automatic drain();
    int cyc = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check_eq("drain_empty", exp_q.size(), 32'd0);
    check_eq("sat_count", {16'd0, sat_count}, {16'd0, model_cnt});
    check_eq("wrap_sat_count", {16'd0, w_sat_count}, 32'd0);
  endtask

  // Presents n random pairs; valid holds until accepted, out_ready low for hold_lo cycles.
  task automatic run_stream(input int n, input int pv, input int pr, input int hold_lo);
    int sent = 0;
    int cyc  = 0;
    bit acc  = 1'b0;
    while (sent < n && cyc < 20000) begin
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      if (sent < n && !in_valid && $urandom_range(99) < pv) begin
        in_valid = 1'b1; in_a = rnd_op(); in_b = rnd_op();
      end
      out_ready = (cyc < hold_lo) ? 1'b0 : ($urandom_range(99) < pr);
      cyc++;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (hold_lo > 0 && cyc == hold_lo) begin
        check_eq("stall_accepted", sent, 32'd2);
        check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
    end
    check_eq("stream_sent", sent, n);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_diff", {16'd0, out_diff}, 32'd0);
    check_eq("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check_eq("rst_sat_count", {16'd0, sat_count}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    send_expect(16'h0005, 16'h0003, 16'h0002, 1'b0, 16'h0002);
    drain();
    send_expect(16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, 16'h8000);
    drain();
    check_eq("sat_count_one", {16'd0, sat_count}, 32'd1);
    send_expect(16'h8000, 16'h0001, 16'h8000, 1'b1, 16'h7FFF);
    drain();
    check_eq("sat_count_two", {16'd0, sat_count}, 32'd2);

    run_stream(10, 100, 100, 5);
    drain();

    run_stream(1000, 70, 60, 0);
    drain();

    // Reset with two results in flight.
    out_ready = 1'b0;
    send_pair(rnd_op(), rnd_op());
    send_pair(rnd_op(), rnd_op());
    @(negedge clk);
    check_eq("inflight_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Clear coinciding with a saturated stage-2 load.
    send_expect(16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, 16'h8000);
    drain();
    check_eq("pre_clr_count", {16'd0, sat_count}, 32'd1);
    @(posedge clk); #1;
    in_a = 16'h8000; in_b = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    check_eq("clr_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; sat_count_clr = 1'b1;
    @(posedge clk); #1;
    sat_count_clr = 1'b0;
    model_cnt = 16'd0;
    @(negedge clk);
    check_eq("clr_wins", {16'd0, sat_count}, 32'd0);
    check_eq("clr_out_sat", {31'd0, out_sat}, 32'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fix_sub_pipe.md
FIX_SUB_PIPE -- requirements
Module: fix_sub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning total two's-complement fixed-point width of operands and result.
REQ-002 The block SHALL have parameter SAT_EN, default 1, meaning 1 = saturate on overflow, 0 = wrap modulo 2^WIDTH.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  operand pair present.
REQ-006 The block SHALL have port in_ready  output  1  block accepts operand pair this cycle.
REQ-007 The block SHALL have port in_a  input  WIDTH  minuend, signed.
REQ-008 The block SHALL have port in_b  input  WIDTH  subtrahend, signed.
REQ-009 The block SHALL have port out_valid  output  1  result present.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 The block SHALL have port out_diff  output  WIDTH  result in_a - in_b, signed.
REQ-012 The block SHALL have port out_sat  output  1  out_diff was clipped (always 0 when SAT_EN=0).
REQ-013 The block SHALL have port sat_count  output  16  number of saturated results loaded into stage 2.
REQ-014 The block SHALL have port sat_count_clr  input  1  clear sat_count.

Function
REQ-015 A transfer SHALL occur on an edge where valid and ready are both high; only then is data consumed.
REQ-016 Stage 1 SHALL register the full WIDTH+1-bit signed difference of the sign-extended operands; stage 2 SHALL register the saturated/wrapped WIDTH-bit result and out_sat.
REQ-017 Latency SHALL be exactly 2 cycles from input transfer to out_valid high when out_ready stays high; throughput SHALL be 1 result/cycle.
REQ-018 Each stage SHALL load when it is empty or its contents leave the same cycle; in_ready SHALL equal (!s1_valid || s2_advances), where s2_advances = (!out_valid || out_ready).
REQ-019 While out_valid && !out_ready, out_diff, out_sat and out_valid SHALL stay stable and no data SHALL be lost or duplicated; the 2-stage pipeline SHALL hold up to 2 results.
REQ-020 With SAT_EN=1: diff > 2^(WIDTH-1)-1 SHALL give 0x7FFF (WIDTH=16) with out_sat=1; diff < -2^(WIDTH-1) SHALL give 0x8000 with out_sat=1; otherwise diff unchanged, out_sat=0.
REQ-021 With SAT_EN=0, out_diff SHALL be the low WIDTH bits of the difference and out_sat SHALL be 0.
REQ-022 sat_count SHALL increment by 1 on each stage-2 load of a saturated result and SHALL stick at 0xFFFF.
REQ-023 If sat_count_clr and an increment coincide, clear SHALL win (sat_count=0).
REQ-024 Results SHALL emerge in input order.

Reset
REQ-025 On rst high at a clock edge: s1_valid=0, out_valid=0, out_diff=0, out_sat=0, sat_count=0; in_ready SHALL be 1 the cycle after reset deasserts.
REQ-026 Reset mid-operation SHALL discard all in-flight results; none SHALL appear afterwards.
REQ-027 While rst is high, in_ready SHALL be 0 and no transfer SHALL be counted.

Structure
REQ-028 A shared package fix_pkg SHALL hold WIDTH default, FIX_MAX/FIX_MIN constants and the saturation function, reused by adder/subtractor blocks.
REQ-029 One combinational sub-module fix_sat (WIDTH+1 in, WIDTH out + sat flag) SHALL implement REQ-020/021; pipeline control stays in fix_sub_pipe.

Verification
REQ-030 a=0x0005, b=0x0003, out_ready=1 -> out_diff=0x0002, out_sat=0, out_valid exactly 2 cycles after transfer.
REQ-031 a=0x7FFF, b=0xFFFF (-1) -> out_diff=0x7FFF, out_sat=1, sat_count=1; a=0x8000, b=0x0001 -> 0x8000, out_sat=1, sat_count=2; same with SAT_EN=0 -> 0x8000 and 0x7FFF, out_sat=0.
REQ-032 Stream 10 pairs with out_ready held low 5 cycles -> in_ready drops after 2 accepted, outputs stable, all 10 results delivered in order, no drop/duplication.
REQ-033 Random valid/ready toggling, 1000 pairs -> scoreboard matches reference model, count of saturations equals sat_count.
REQ-034 Assert rst with 2 results in flight -> out_valid=0 next cycle, no stale result after release; sat_count_clr coincident with saturation -> sat_count=0.
